pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Pipeline stall/flush controller for the five-stage MIPS datapath. It is the receiving end of the hazard detector's stall request. It consumes the hazard request, the taken-branch flush and the data-memory busy signal, and drives the PC, IF/ID and ID/EX write-enable, flush and bubble controls. A small state machine sequences bubble insertion, freezes and flushes, and saturating counters record stall activity.

## Interface
- CNT_W, 16, width of the stall-cycle counter
- MAX_STALL, 8, consecutive hazard-stall cycles before stall_timeout sets
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- hazard_req  in  1  load-use stall request from hazard detector; 1 = stall ID
- branch_taken  in  1  branch resolved taken in EX; wrong-path IF/ID and ID instructions must be squashed
- mem_busy  in  1  data memory not ready; whole pipeline must freeze
- pc_we  out  1  PC write enable; 1 = PC advances
- ifid_we  out  1  IF/ID register write enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_bubble  out  1  select NOP control word into ID/EX
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB registers
- stall_cycles  out  CNT_W  saturating count of cycles with pc_we = 0
- stall_timeout  out  1  sticky; set when hazard_req stays high for more than MAX_STALL consecutive cycles

## Operation
- States: RUN, LU_STALL, MEM_FRZ, FLUSH. Reset enters RUN.
- Input priority in every state: mem_busy > branch_taken > hazard_req.
- RUN:
  - mem_busy=1: pc_we=0, ifid_we=0, pipe_freeze=1; go to MEM_FRZ.
  - else branch_taken=1: ifid_flush=1, idex_bubble=1, pc_we=1; go to FLUSH.
  - else hazard_req=1: pc_we=0, ifid_we=0, idex_bubble=1; go to LU_STALL.
  - else: pc_we=1, ifid_we=1, all other controls 0.
- LU_STALL: one cycle.
  - hazard_req is masked, because the load has moved to MEM and forwarding covers it.
  - Normal enables apply.
  - Returns to RUN, subject to mem_busy and branch_taken priority.
- MEM_FRZ:
  - Freeze outputs are held while mem_busy=1.
  - branch_taken and hazard_req are ignored, since the frozen stages present the same values again after release.
  - When mem_busy=0, outputs in that cycle are as in RUN and the next state follows RUN's rules.
- FLUSH: one cycle.
  - hazard_req is masked, because the ID instruction is wrong-path.
  - Normal enables apply.
  - Returns to RUN; mem_busy priority still applies.
- branch_taken and hazard_req in the same cycle: flush wins and no stall is taken.
- stall_cycles:
  - Increments on every clock with pc_we=0.
  - Saturates at 2^CNT_W−1 and never wraps.
- stall_timeout:
  - A run counter increments while hazard_req=1 in RUN or LU_STALL.
  - The run counter clears when hazard_req=0.
  - stall_timeout sets when the run counter exceeds MAX_STALL.
  - Once set, stall_timeout clears only on reset.

## Timing
- Controls are combinational (Mealy) from state and inputs, with 0-cycle latency, so a request stalls the PC on the same edge.
- State, counters and timeout register on the rising clk edge.
- While reset=0: state=RUN, pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=0, pipe_freeze=1, stall_cycles=0, stall_timeout=0.
  - These reset-time stall cycles are not counted.
- The first edge after reset release runs in RUN with pc_we=1.
- Reset asserted mid-stall or mid-flush aborts immediately and asynchronously; there is no pending-state carry-over.
- A load-use hazard costs exactly 1 bubble cycle.
- A taken branch costs 1 flush cycle with 2 instructions squashed.
- A memory freeze lasts exactly the number of cycles mem_busy is high.

## Structure
- Shared package pipe_ctrl_pkg:
  - state enum (RUN=2'b00, LU_STALL=2'b01, MEM_FRZ=2'b10, FLUSH=2'b11)
  - control-word NOP constant used by the ID/EX bubble mux
- Sub-module sat_counter (parameter W; inputs inc, clr; output count) saturates at its maximum. It is instantiated twice:
  - stall_cycles, with W = CNT_W
  - the hazard run counter, with W = $clog2(MAX_STALL+2)

## Test plan
- Reset release, no requests: pc_we=ifid_we=1 from the first edge; stall_cycles stays 0 over 20 cycles.
- hazard_req high for 1 cycle in RUN:
  - same cycle: pc_we=0, idex_bubble=1
  - next cycle: LU_STALL with hazard_req masked (pc_we=1 even if hazard_req is still 1)
  - stall_cycles=1
- branch_taken and hazard_req together: ifid_flush=1, idex_bubble=1, pc_we=1; no LU_STALL entered; stall_cycles unchanged.
- mem_busy high for 5 cycles, with branch_taken pulsed mid-freeze: pipe_freeze=1 and pc_we=0 for exactly 5 cycles; branch ignored; stall_cycles=5.
- hazard_req held for MAX_STALL+1 cycles (8 → 9): stall_timeout rises after the 9th and stays 1 after hazard_req drops, until reset.
- With CNT_W=4 and 20 stall cycles, stall_cycles saturates at 15; reset asserted mid-MEM_FRZ immediately forces state=RUN and stall_cycles=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_FRZ  = 2'b10,
        FLUSH    = 2'b11
    } state_e;

    // Pipeline control bundle driven by the controller each cycle.
    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_freeze;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN_C    = 5'b11000;
    localparam ctrl_t CTRL_STALL_C  = 5'b00010;
    localparam ctrl_t CTRL_FLUSH_C  = 5'b11110;
    localparam ctrl_t CTRL_FREEZE_C = 5'b00001;
    localparam ctrl_t CTRL_RESET_C  = 5'b00001;

    // Control word muxed into ID/EX when a bubble is inserted.
    localparam int         CTRL_WORD_W = 9;
    localparam logic [8:0] CTRL_NOP    = 9'h000;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Up-counter that sticks at its maximum value; clr has priority over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {W{1'b0}};
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the five-stage pipeline: Mealy control outputs
// from a four-state sequencer, plus stall-cycle and hazard-timeout tracking.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hazard_req,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             stall_timeout
);

    localparam int RUN_W = $clog2(MAX_STALL + 2);

    state_e             state_q;
    state_e             state_d;
    ctrl_t              ctrl_s;
    logic               run_inc_s;
    logic               run_clr_s;
    logic [RUN_W-1:0]   run_cnt_s;
    logic               timeout_q;
    logic               timeout_d;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: mem_busy > branch_taken > hazard_req; MEM_FRZ releases into RUN rules.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN, MEM_FRZ: begin
                if (mem_busy)          state_d = MEM_FRZ;
                else if (branch_taken) state_d = FLUSH;
                else if (hazard_req)   state_d = LU_STALL;
                else                   state_d = RUN;
            end
            LU_STALL: begin
                if (mem_busy)          state_d = MEM_FRZ;
                else if (branch_taken) state_d = FLUSH;
                else                   state_d = RUN;
            end
            FLUSH: begin
                if (mem_busy) state_d = MEM_FRZ;
                else          state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Output decode; reset forces a frozen, non-advancing pipeline.
    always_comb begin
        ctrl_s = CTRL_RUN_C;
        if (!reset) begin
            ctrl_s = CTRL_RESET_C;
        end else begin
            case (state_q)
                RUN, MEM_FRZ: begin
                    if (mem_busy)          ctrl_s = CTRL_FREEZE_C;
                    else if (branch_taken) ctrl_s = CTRL_FLUSH_C;
                    else if (hazard_req)   ctrl_s = CTRL_STALL_C;
                    else                   ctrl_s = CTRL_RUN_C;
                end
                LU_STALL: begin
                    if (mem_busy)          ctrl_s = CTRL_FREEZE_C;
                    else if (branch_taken) ctrl_s = CTRL_FLUSH_C;
                    else                   ctrl_s = CTRL_RUN_C;
                end
                FLUSH: begin
                    if (mem_busy) ctrl_s = CTRL_FREEZE_C;
                    else          ctrl_s = CTRL_RUN_C;
                end
                default: ctrl_s = CTRL_RESET_C;
            endcase
        end
    end

    assign pc_we       = ctrl_s.pc_we;
    assign ifid_we     = ctrl_s.ifid_we;
    assign ifid_flush  = ctrl_s.ifid_flush;
    assign idex_bubble = ctrl_s.idex_bubble;
    assign pipe_freeze = ctrl_s.pipe_freeze;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (~ctrl_s.pc_we),
        .clr   (1'b0),
        .count (stall_cycles)
    );

    // Hazard run length only advances where hazard_req is architecturally live;
    // in MEM_FRZ/FLUSH it holds.
    assign run_inc_s = hazard_req && ((state_q == RUN) || (state_q == LU_STALL));
    assign run_clr_s = ~hazard_req;

    sat_counter #(.W(RUN_W)) u_run_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (run_inc_s),
        .clr   (run_clr_s),
        .count (run_cnt_s)
    );

    // Timeout sets on the edge where the run length moves past MAX_STALL.
    always_comb begin
        timeout_d = timeout_q;
        if (run_inc_s && (run_cnt_s >= RUN_W'(MAX_STALL))) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // Sticky timeout register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: per-cycle vector table plus
// hand-written idle, timeout, saturation and async-reset sequences.
module tb_pipeline_stall_ctrl;

    localparam int CNT_W     = 4;
    localparam int MAX_STALL = 8;

    // {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze}
    localparam logic [4:0] R = 5'b11000;
    localparam logic [4:0] S = 5'b00010;
    localparam logic [4:0] L = 5'b11110;
    localparam logic [4:0] F = 5'b00001;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             hazard_req = 1'b0;
    logic             branch_taken = 1'b0;
    logic             mem_busy = 1'b0;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_freeze;
    logic [CNT_W-1:0] stall_cycles;
    logic             stall_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst_n;
        logic       mb;
        logic       bt;
        logic       hz;
        logic [4:0] ctrl;
        logic [3:0] sc;
        logic       to;
        string      name;
    } vec_t;

    vec_t vecs[$];

    pipeline_stall_ctrl #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
        .clk           (clk),
        .reset         (reset),
        .hazard_req    (hazard_req),
        .branch_taken  (branch_taken),
        .mem_busy      (mem_busy),
        .pc_we         (pc_we),
        .ifid_we       (ifid_we),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .pipe_freeze   (pipe_freeze),
        .stall_cycles  (stall_cycles),
        .stall_timeout (stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [4:0] ctrl,
                             input logic [3:0] sc, input logic to);
        chk({name, ".ctrl"}, 32'({pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze}), 32'(ctrl));
        chk({name, ".stall_cycles"}, 32'(stall_cycles), 32'(sc));
        chk({name, ".timeout"}, 32'(stall_timeout), 32'(to));
    endtask

    task automatic add(input logic r, input logic mb, input logic bt, input logic hz,
                       input logic [4:0] ctrl, input logic [3:0] sc, input logic to,
                       input string name);
        vec_t v;
        v.rst_n = r; v.mb = mb; v.bt = bt; v.hz = hz;
        v.ctrl = ctrl; v.sc = sc; v.to = to; v.name = name;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs just after the rising edge; sample at the falling edge.
    task automatic step(input logic r, input logic mb, input logic bt, input logic hz);
        @(posedge clk);
        #1;
        reset = r; mem_busy = mb; branch_taken = bt; hazard_req = hz;
        @(negedge clk);
    endtask

    initial begin
        add(1'b0, 1'b0, 1'b0, 1'b0, F, 4'd0, 1'b0, "reset");
        add(1'b1, 1'b0, 1'b0, 1'b0, R, 4'd0, 1'b0, "release");
        add(1'b1, 1'b0, 1'b0, 1'b1, S, 4'd0, 1'b0, "lu_req");
        add(1'b1, 1'b0, 1'b0, 1'b1, R, 4'd1, 1'b0, "lu_masked");
        add(1'b1, 1'b0, 1'b0, 1'b0, R, 4'd1, 1'b0, "lu_done");
        add(1'b0, 1'b0, 1'b0, 1'b0, F, 4'd0, 1'b0, "reset2");
        add(1'b1, 1'b0, 1'b0, 1'b0, R, 4'd0, 1'b0, "idle");
        add(1'b1, 1'b0, 1'b1, 1'b1, L, 4'd0, 1'b0, "br_and_hz");
        add(1'b1, 1'b0, 1'b0, 1'b1, R, 4'd0, 1'b0, "flush_masked");
        add(1'b1, 1'b0, 1'b0, 1'b0, R, 4'd0, 1'b0, "after_flush");
        add(1'b1, 1'b1, 1'b0, 1'b0, F, 4'd0, 1'b0, "frz1");
        add(1'b1, 1'b1, 1'b0, 1'b0, F, 4'd1, 1'b0, "frz2");
        add(1'b1, 1'b1, 1'b1, 1'b0, F, 4'd2, 1'b0, "frz3_br");
        add(1'b1, 1'b1, 1'b0, 1'b0, F, 4'd3, 1'b0, "frz4");
        add(1'b1, 1'b1, 1'b0, 1'b0, F, 4'd4, 1'b0, "frz5");
        add(1'b1, 1'b0, 1'b0, 1'b1, S, 4'd5, 1'b0, "frz_rel_hz");
        add(1'b1, 1'b0, 1'b0, 1'b1, R, 4'd6, 1'b0, "lu_after_frz");
        add(1'b1, 1'b0, 1'b0, 1'b0, R, 4'd6, 1'b0, "idle2");
        add(1'b1, 1'b0, 1'b0, 1'b1, S, 4'd6, 1'b0, "lu_req2");
        add(1'b1, 1'b0, 1'b1, 1'b0, L, 4'd7, 1'b0, "lu_branch");
        add(1'b1, 1'b0, 1'b0, 1'b0, R, 4'd7, 1'b0, "flush_after_lu");
        add(1'b1, 1'b0, 1'b0, 1'b1, S, 4'd7, 1'b0, "lu_req3");
        add(1'b1, 1'b1, 1'b0, 1'b0, F, 4'd8, 1'b0, "lu_mem");
        add(1'b1, 1'b0, 1'b0, 1'b0, R, 4'd9, 1'b0, "frz_rel");

        reset = 1'b0;
        repeat (2) @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].mb, vecs[i].bt, vecs[i].hz);
            check_all(vecs[i].name, vecs[i].ctrl, vecs[i].sc, vecs[i].to);
        end

        // Idle after reset: no stall counting over 20 cycles.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check_all("idle20", R, 4'd0, 1'b0);
        end

        // Hazard held exactly MAX_STALL cycles: no timeout.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < MAX_STALL; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            check_all("hold8", (i % 2 == 0) ? S : R, 4'(i / 2 + i % 2), 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("after_hold8", R, 4'd4, 1'b0);

        // Hazard held MAX_STALL+1 cycles: timeout rises after the last one.
        for (int i = 0; i < MAX_STALL + 1; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            check_all("hold9", (i % 2 == 0) ? S : R, 4'(4 + i / 2 + i % 2), 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("after_hold9", R, 4'd9, 1'b1);
        repeat (3) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check_all("timeout_sticky", R, 4'd9, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_all("timeout_reset", F, 4'd0, 1'b0);

        // 20 freeze cycles saturate the 4-bit counter; async reset mid-freeze.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("sat15", F, 4'd15, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset_mid_frz", F, 4'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("run_after_async_reset", R, 4'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
